block_buffer_ram: RTL and testbench



---
 rtl/block_buffer_ram.sv | 87 ++++++++
 tb/tb_block_buffer_ram.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/block_buffer_ram.sv
// ----------------------------------------------------------------------------
// block_buffer_ram
//
// Simple dual-port sample buffer between the acquisition front-end and the
// SDRAM scheduler. One write port and one read port share a single clock.
// There is no write enable: every clock edge outside reset stores a word.
// Reads are synchronous and read-first on a same-address collision. The
// caller owns all addressing, including pointer wrap.
//
// Optional feature (compile-time macro BLOCK_BUFFER_OUTREG_EN):
//   When defined, a second register follows the RAM output stage, and read
//   latency becomes 2 cycles. When undefined, read latency is 1 cycle.
//
// Parameters:
//   DATA_WIDTH  width of each stored word (default 24)
//   ADDR_WIDTH  width of read/write addresses (default 9)
//   DEPTH       number of words, 2**ADDR_WIDTH (default 512)
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset (output registers only)
//   write_data     in   word written on every edge with rst_n high
//   write_address  in   write location
//   read_address   in   read location
//   read_data      out  registered read result
// ----------------------------------------------------------------------------
module block_buffer_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] read_data
);

    // Storage array. The declaration initialiser gives zeroed contents at
    // power-up in simulation and as the FPGA init image. The array carries no
    // reset, so it maps onto a single block RAM.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

    // RAM output stage.
    logic [DATA_WIDTH-1:0] ram_q;

    // Write port. rst_n is sampled at the edge rather than used as an
    // asynchronous reset, because the array itself must never be cleared.
    // This suppresses any write while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem[write_address] <= write_data;
        end
    end

    // Read port. The non-blocking write above lands only after this read has
    // sampled the array. A same-address collision therefore returns the old
    // word (read-first). The asynchronous reset clears only this register.
    // Any read in flight when reset asserts is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q <= '0;
        end else begin
            ram_q <= mem[read_address];
        end
    end

`ifdef BLOCK_BUFFER_OUTREG_EN
    // Extra output pipeline stage, used for timing closure on long routes
    // into the scheduler. It resets together with the RAM stage.
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= ram_q;
        end
    end

    assign read_data = out_q;
`else
    assign read_data = ram_q;
`endif

endmodule

// File: tb/tb_block_buffer_ram.sv
// ----------------------------------------------------------------------------
// tb_block_buffer_ram
//
// Self-checking bench for block_buffer_ram. A behavioural model holds the
// memory as a plain array. It also holds the pending read results as a
// queue that is LAT entries deep. Each cycle the model reads (old contents
// first), applies the write, and shifts the queue. The model is compared with
// read_data on the falling edge. Directed steps reproduce the reset, basic,
// read-during-write, wrap, streaming and async-reset scenarios. A randomised
// phase then stresses collisions and the full address range.
// ----------------------------------------------------------------------------
module tb_block_buffer_ram;

`ifdef BLOCK_BUFFER_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [8:0] PARK = 9'd300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] write_data = '0;
    logic [8:0]  write_address = '0;
    logic [8:0]  read_address = '0;
    logic [23:0] read_data;

    int checks = 0;
    int errors = 0;

    logic [23:0] model_mem [512];
    logic [23:0] exp_pipe [$];

    block_buffer_ram dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_data    (write_data),
        .write_address (write_address),
        .read_address  (read_address),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs.
    // The !== operator makes an X on read_data count as a mismatch.
    task automatic checkOutput(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Clears the model's view of the output registers, as reset does.
    task automatic modelReset();
        exp_pipe.delete();
        for (int i = 0; i < LAT; i++) exp_pipe.push_back(24'h0);
    endtask

    // Drives one cycle. The task is entered just after a falling edge.
    // It sets the inputs, advances the model on the rising edge, and
    // checks the output on the next falling edge.
    task automatic applyStimulus(input string tag, input logic [8:0] wa,
                                 input logic [23:0] wd, input logic [8:0] ra);
        logic [23:0] rv;
        write_address = wa;
        write_data    = wd;
        read_address  = ra;
        @(posedge clk);
        if (rst_n) begin
            rv = model_mem[ra];
            model_mem[wa] = wd;
            exp_pipe.push_back(rv);
            void'(exp_pipe.pop_front());
        end else begin
            modelReset();
        end
        @(negedge clk);
        checkOutput(tag, read_data, exp_pipe[0]);
    endtask

    // Presents a read address for LAT cycles while writes go to a parked
    // address. It then checks read_data against a bench-chosen constant.
    task automatic readBack(input string tag, input logic [8:0] addr,
                            input logic [23:0] expected);
        for (int i = 0; i < LAT; i++) applyStimulus("rb_model", PARK, 24'h5A5A5A, addr);
        checkOutput(tag, read_data, expected);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model_mem[i] = 24'h0;
        modelReset();

        // Reset held for 3 cycles while a write to address 5 is attempted.
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_async", read_data, 24'h0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus("reset_hold", 9'd5, 24'hABCDEF, 9'd5);
        rst_n = 1'b1;
        readBack("reset_suppressed_write", 9'd5, 24'h0);

        // Basic write of 1..16 to addresses 0..15, then read back.
        for (int i = 0; i < 16; i++)
            applyStimulus("basic_wr", 9'(i), 24'(i + 1), PARK);
        for (int i = 0; i < 16; i++)
            readBack($sformatf("basic_rd%0d", i), 9'(i), 24'(i + 1));

        // Read-during-write on address 7 returns the old word first.
        applyStimulus("rdw_prep", 9'd7, 24'h111111, PARK);
        applyStimulus("rdw_edge", 9'd7, 24'h222222, 9'd7);
        for (int i = 1; i < LAT; i++) applyStimulus("rdw_wait", PARK, 24'h0, 9'd7);
        checkOutput("rdw_old", read_data, 24'h111111);
        readBack("rdw_new", 9'd7, 24'h222222);

        // Write addresses 510, 511 and 0 (natural wrap) with data = addr + 1.
        applyStimulus("wrap_wr", 9'd510, 24'd511, PARK);
        applyStimulus("wrap_wr", 9'd511, 24'd512, PARK);
        applyStimulus("wrap_wr", 9'd510 + 9'd2, 24'd1, PARK);
        readBack("wrap_510", 9'd510, 24'd511);
        readBack("wrap_511", 9'd511, 24'd512);
        readBack("wrap_0", 9'd0, 24'd1);

        // Streaming: the read address trails the write address by one.
        for (int i = 0; i < 40; i++)
            applyStimulus("stream", 9'(200 + i), 24'($urandom), 9'(199 + i));

        // Random traffic. Half the cycles use a tiny address window so that
        // collisions are frequent.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0)
                applyStimulus("rand_narrow", 9'($urandom_range(0, 7)), 24'($urandom),
                              9'($urandom_range(0, 7)));
            else
                applyStimulus("rand_wide", 9'($urandom_range(0, 511)), 24'($urandom),
                              9'($urandom_range(0, 511)));
        end

        // Fixed content written just before the mid-stream reset.
        applyStimulus("pre_rst_wr", 9'd400, 24'hC0FFEE, 9'd0);
        applyStimulus("pre_rst_wr", 9'd401, 24'hBEEF01, 9'd400);

        // Reset asserted between edges. The output must clear without a
        // clock edge. Writes attempted during reset must not land.
        #2 rst_n = 1'b0;
        #1 checkOutput("midrst_async", read_data, 24'h0);
        modelReset();
        applyStimulus("midrst_hold", 9'd400, 24'h0BAD00, 9'd401);
        applyStimulus("midrst_hold", 9'd401, 24'h0BAD01, 9'd400);
        rst_n = 1'b1;
        readBack("midrst_keep400", 9'd400, 24'hC0FFEE);
        readBack("midrst_keep401", 9'd401, 24'hBEEF01);
        for (int i = 0; i < 16; i++)
            applyStimulus("post_rst_model", PARK, 24'($urandom), 9'($urandom_range(0, 511)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
